// File: rtl/regfile_sequencer_if.sv
// ----------------------------------------------------------------------------
// regfile_sequencer_if
// Purpose : bundles the instruction handshake and the regfile/ALU control
//           signals of regfile_sequencer into one interface.
// Signals :
//   instr_valid, instr, stall         fetch side -> sequencer
//   instr_ready                       sequencer -> fetch side
//   rf_src_addr, rf_dst_addr,
//   rf_write_en                       sequencer -> register file
//   alu_op, imm_sel, imm_out,
//   psr_write_en                      sequencer -> ALU / PSR
//   busy, done, illegal               sequencer status
// Modports: master = fetch/control side, slave = the sequencer itself.
// ----------------------------------------------------------------------------
interface regfile_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REGBITS    = 4
);
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_ready;
    logic                  stall;
    logic [REGBITS-1:0]    rf_src_addr;
    logic [REGBITS-1:0]    rf_dst_addr;
    logic                  rf_write_en;
    logic [3:0]            alu_op;
    logic                  imm_sel;
    logic [DATA_WIDTH-1:0] imm_out;
    logic                  psr_write_en;
    logic                  busy;
    logic                  done;
    logic                  illegal;

    modport master (
        output instr_valid, instr, stall,
        input  instr_ready, rf_src_addr, rf_dst_addr, rf_write_en,
               alu_op, imm_sel, imm_out, psr_write_en, busy, done, illegal
    );

    modport slave (
        input  instr_valid, instr, stall,
        output instr_ready, rf_src_addr, rf_dst_addr, rf_write_en,
               alu_op, imm_sel, imm_out, psr_write_en, busy, done, illegal
    );
endinterface

// File: rtl/regfile_sequencer.sv
// ----------------------------------------------------------------------------
// regfile_sequencer
// Purpose : multi-cycle controller that runs one register-register (R-form)
//           or register-immediate (I-form) instruction through the phases
//           READ -> EXEC -> WRITE, driving regfile addresses, the ALU op,
//           the immediate operand and the write enables.
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    regfile_sequencer_if.slave (handshake, regfile/ALU controls,
//          status pulses)
// Instruction word: [15:12] opcode, [11:8] Rdest, [7:4] op-ext, [3:0] Rsrc
// ----------------------------------------------------------------------------
module regfile_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int REGBITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_instr;

    logic                  w_ready;
    logic                  w_busy;
    logic                  w_is_rform;
    logic [3:0]            w_op;
    logic                  w_legal;
    logic                  w_sets_psr;
    logic                  w_writes_rf;
    logic [DATA_WIDTH-1:0] w_imm;

    function automatic logic op_defined(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR) ||
               (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
               (op == OP_MOV);
    endfunction

    // Logical ops take the byte as an unsigned mask; arithmetic ops and MOV
    // treat it as a signed constant.
    function automatic logic [DATA_WIDTH-1:0] extend_imm(input logic [3:0] op,
                                                          input logic [7:0] b);
        if ((op == OP_AND) || (op == OP_OR) || (op == OP_XOR))
            return {{(DATA_WIDTH-8){1'b0}}, b};
        else
            return {{(DATA_WIDTH-8){b[7]}}, b};
    endfunction

    // The word is latched only on an accepted handshake, so anything offered
    // while busy is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_instr <= '0;
        end else if (!bus.stall) begin
            case (r_state)
                IDLE: begin
                    if (bus.instr_valid && w_ready) begin
                        r_instr <= bus.instr;
                        r_state <= READ;
                    end
                end
                READ:    r_state <= EXEC;
                EXEC:    r_state <= WRITE;
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decode is taken from the latched word, so addresses and operands stay
    // stable for the whole instruction and across stalls.
    assign w_is_rform  = (r_instr[15:12] == 4'b0000);
    assign w_op        = w_is_rform ? r_instr[7:4] : r_instr[15:12];
    assign w_legal     = op_defined(w_op);
    assign w_sets_psr  = w_legal && ((w_op == OP_ADD) || (w_op == OP_SUB) ||
                                     (w_op == OP_CMP));
    assign w_writes_rf = w_legal && (w_op != OP_CMP);
    assign w_imm       = w_is_rform ? '0 : extend_imm(w_op, r_instr[7:0]);

    // Ready is gated by reset so it is low during reset even though the
    // state register already sits in IDLE; a stall also withholds it so a
    // handshake is never offered that the frozen FSM would not take.
    assign w_ready = !reset && (r_state == IDLE) && !bus.stall;
    assign w_busy  = (r_state != IDLE);

    assign bus.instr_ready  = w_ready;
    assign bus.busy         = w_busy;
    assign bus.rf_src_addr  = w_is_rform ? REGBITS'(r_instr[3:0]) : '0;
    assign bus.rf_dst_addr  = w_busy ? REGBITS'(r_instr[11:8]) : '0;
    assign bus.alu_op       = w_op;
    assign bus.imm_sel      = !w_is_rform;
    assign bus.imm_out      = w_imm;

    // Side-effecting pulses are suppressed in any stalled cycle so that a
    // frozen phase never writes twice.
    assign bus.psr_write_en = (r_state == EXEC)  && !bus.stall && w_sets_psr;
    assign bus.illegal      = (r_state == EXEC)  && !bus.stall && !w_legal;
    assign bus.rf_write_en  = (r_state == WRITE) && !bus.stall && w_writes_rf;
    assign bus.done         = (r_state == WRITE) && !bus.stall;

endmodule

// File: tb/tb_regfile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_regfile_sequencer
// Directed bench for regfile_sequencer. A behavioural model tracks the
// instruction in flight and the phase it is in; a compare process checks
// every DUT output against it on each falling edge, while the directed
// sequence adds literal expectations for the listed instructions.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sequencer_if #(.DATA_WIDTH(16), .REGBITS(4)) bus ();

    regfile_sequencer #(.DATA_WIDTH(16), .REGBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [3:0]  op;
        logic        sel;
        logic [15:0] imm;
        logic        legal;
        logic        psr;
        logic        wr;
    } rec_t;

    function automatic rec_t decode(input logic [15:0] w);
        rec_t r;
        int   b;
        b     = int'(w[7:0]);
        r.dst = w[11:8];
        if (w[15:12] == 4'd0) begin
            r.op  = w[7:4];
            r.sel = 1'b0;
            r.src = w[3:0];
            r.imm = 16'd0;
        end else begin
            r.op  = w[15:12];
            r.sel = 1'b1;
            r.src = 4'd0;
            if (r.op inside {4'd1, 4'd2, 4'd3}) r.imm = 16'(b);
            else                                r.imm = 16'((b >= 128) ? b - 256 : b);
        end
        r.legal = r.op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13};
        r.psr   = r.legal && (r.op inside {4'd5, 4'd9, 4'd11});
        r.wr    = r.legal && (r.op != 4'd11);
        return r;
    endfunction

    // m_phase counts cycles into the instruction: 0 = idle, 1..3 = the three
    // phases; a stalled cycle does not advance it.
    int   m_phase;
    rec_t m_rec;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_rec   <= decode(16'h0000);
        end else if (!bus.stall) begin
            if (m_phase == 0) begin
                if (bus.instr_valid) begin
                    m_rec   <= decode(bus.instr);
                    m_phase <= 1;
                end
            end else begin
                m_phase <= (m_phase + 1) % 4;
            end
        end
    end

    int wr_cnt   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        logic run;
        run = !reset && !bus.stall;
        check("instr_ready",  32'(bus.instr_ready),  32'(!reset && m_phase == 0 && !bus.stall));
        check("busy",         32'(bus.busy),         32'(m_phase != 0));
        check("rf_src_addr",  32'(bus.rf_src_addr),  32'(m_rec.src));
        check("rf_dst_addr",  32'(bus.rf_dst_addr),  32'((m_phase != 0) ? m_rec.dst : 4'd0));
        check("alu_op",       32'(bus.alu_op),       32'(m_rec.op));
        check("imm_sel",      32'(bus.imm_sel),      32'(m_rec.sel));
        check("imm_out",      32'(bus.imm_out),      32'(m_rec.imm));
        check("psr_write_en", 32'(bus.psr_write_en), 32'(run && m_phase == 2 && m_rec.psr));
        check("illegal",      32'(bus.illegal),      32'(run && m_phase == 2 && !m_rec.legal));
        check("rf_write_en",  32'(bus.rf_write_en),  32'(run && m_phase == 3 && m_rec.wr));
        check("done",         32'(bus.done),         32'(run && m_phase == 3));
        if (bus.rf_write_en) wr_cnt++;
        if (bus.done)        done_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [15:0] w);
        check("ready_before_issue", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        cyc();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.stall       = 1'b0;
        cyc();
        cyc();
        check("reset_ready", 32'(bus.instr_ready), 32'd0);
        check("reset_busy",  32'(bus.busy),        32'd0);
        check("reset_dst",   32'(bus.rf_dst_addr), 32'd0);
        reset = 1'b0;
        cyc();

        // ADD R3,R5
        offer(16'h0355);
        check("add_read_src", 32'(bus.rf_src_addr), 32'd5);
        check("add_read_dst", 32'(bus.rf_dst_addr), 32'd3);
        check("add_read_sel", 32'(bus.imm_sel),     32'd0);
        cyc();
        check("add_exec_op",  32'(bus.alu_op),       32'h5);
        check("add_exec_psr", 32'(bus.psr_write_en), 32'd1);
        cyc();
        check("add_wb_wr",   32'(bus.rf_write_en), 32'd1);
        check("add_wb_done", 32'(bus.done),        32'd1);
        cyc();
        check("add_ready_back", 32'(bus.instr_ready), 32'd1);

        // ADDI R2,#-1
        offer(16'h52FF);
        check("addi_imm", 32'(bus.imm_out), 32'hFFFF);
        check("addi_sel", 32'(bus.imm_sel), 32'd1);
        check("addi_src", 32'(bus.rf_src_addr), 32'd0);
        cyc();
        check("addi_op", 32'(bus.alu_op), 32'h5);
        cyc();
        check("addi_wr",  32'(bus.rf_write_en), 32'd1);
        check("addi_dst", 32'(bus.rf_dst_addr), 32'd2);
        cyc();

        // ANDI R1,#0x80
        offer(16'h1180);
        check("andi_imm", 32'(bus.imm_out), 32'h0080);
        check("andi_op",  32'(bus.alu_op),  32'h1);
        cyc();
        check("andi_psr", 32'(bus.psr_write_en), 32'd0);
        cyc();
        check("andi_wr", 32'(bus.rf_write_en), 32'd1);
        cyc();

        // CMP R4,R6
        offer(16'h04B6);
        check("cmp_src", 32'(bus.rf_src_addr), 32'd6);
        cyc();
        check("cmp_psr", 32'(bus.psr_write_en), 32'd1);
        check("cmp_op",  32'(bus.alu_op),       32'hB);
        cyc();
        check("cmp_wr",   32'(bus.rf_write_en), 32'd0);
        check("cmp_done", 32'(bus.done),        32'd1);
        cyc();

        // undefined opcode 0111
        offer(16'h7000);
        cyc();
        check("ill_pulse", 32'(bus.illegal),      32'd1);
        check("ill_psr",   32'(bus.psr_write_en), 32'd0);
        cyc();
        check("ill_wr",   32'(bus.rf_write_en), 32'd0);
        check("ill_done", 32'(bus.done),        32'd1);
        cyc();

        // ADD with a 3-cycle stall in EXEC and instr_valid held high
        offer(16'h0355);
        bus.instr_valid = 1'b1;
        cyc();
        bus.stall = 1'b1;
        #1;
        check("stall_psr", 32'(bus.psr_write_en), 32'd0);
        check("stall_dst", 32'(bus.rf_dst_addr),  32'd3);
        cyc();
        cyc();
        cyc();
        bus.stall = 1'b0;
        #1;
        check("stall_exec_resume", 32'(bus.psr_write_en), 32'd1);
        cyc();
        check("stall_wb_done", 32'(bus.done), 32'd1);
        bus.instr_valid = 1'b0;
        cyc();
        check("stall_done_count", 32'(done_cnt), 32'd6);
        check("stall_wr_count",   32'(wr_cnt),   32'd4);

        // reset in EXEC aborts the write
        offer(16'h0355);
        cyc();
        reset = 1'b1;
        #1;
        check("abort_busy",  32'(bus.busy),         32'd0);
        check("abort_ready", 32'(bus.instr_ready),  32'd0);
        check("abort_psr",   32'(bus.psr_write_en), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        check("abort_ready_after", 32'(bus.instr_ready), 32'd1);
        check("abort_wr_count",    32'(wr_cnt),          32'd4);

        offer(16'h0355);
        cyc();
        cyc();
        check("post_reset_wr", 32'(bus.rf_write_en), 32'd1);
        cyc();

        // R-form with op-ext 0000 is undefined
        offer(16'h0300);
        cyc();
        check("rill_pulse", 32'(bus.illegal), 32'd1);
        cyc();
        cyc();
        check("final_done_count", 32'(done_cnt), 32'd8);
        check("final_wr_count",   32'(wr_cnt),   32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
